md_read_sequencer: RTL and testbench

Control sequencer for one PE's position-read path. It drives the global `phase`, `reading_particle_num`, `pause_reading`, `ref_id` and `particle_id` signals consumed by the position preprocessor and the neighbour-cell position RAMs. It first reads the home-cell particle count, then steps every reference particle through a full two-phase broadcast of the cell's particles. It stalls on filter back-pressure and reports completion to the top-level MD controller.

---
 rtl/md_read_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_md_read_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/md_read_sequencer.sv
// ---------------------------------------------------------------------------
// md_read_sequencer
//
// Position-read control sequencer for one PE. It first reads the home-cell
// particle count (address 0), then steps every reference particle through
// a two-phase broadcast of all particles in the cell. Reading stalls while
// any filter reports almost-full, and a one-cycle done pulse reports
// completion to the MD controller.
//
// Parameters:
//   PARTICLE_ID_WIDTH  width of particle IDs, counts and RAM addresses
//   NUM_FILTER         number of filters supplying back-pressure
//
// Ports:
//   clk                   clock
//   rst                   synchronous, active-high reset
//   start                 one-cycle pulse; begins a pass when idle
//   filter_almost_full    per-filter back-pressure (any bit stalls)
//   home_particle_count   home-cell particle count, sampled in WAIT_CNT
//   phase                 global phase (0/1)
//   reading_particle_num  high while the count word (address 0) is read
//   pause_reading         combinational stall indicator
//   ref_id                current reference particle ID (1-based)
//   particle_id           current broadcast particle ID / RAM address
//   busy                  high from accepted start until done
//   done                  one-cycle completion pulse
//   stall_cycles          stalled-cycle count for the pass
//                         (only when MD_SEQ_STALL_CNT_EN is defined)
//
// Optional feature macro: MD_SEQ_STALL_CNT_EN
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for start, all outputs at rest
// S_RD_NUM0  | reading count word, phase 0
// S_RD_NUM1  | reading count word, phase 1
// S_WAIT_CNT | count arrives from RAM; latch it and choose next state
// S_BCAST    | stepping (ref_id, particle_id, phase) through the cell
// S_FINISH   | done pulse visible, return to idle
// ---------------------------------------------------------------------------
module md_read_sequencer #(
   parameter int PARTICLE_ID_WIDTH = 7,
   parameter int NUM_FILTER        = 7
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [NUM_FILTER-1:0]        filter_almost_full,
   input  logic [PARTICLE_ID_WIDTH-1:0] home_particle_count,
   output logic                         phase,
   output logic                         reading_particle_num,
   output logic                         pause_reading,
   output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
   output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
   output logic                         busy,
`ifdef MD_SEQ_STALL_CNT_EN
   output logic [31:0]                  stall_cycles,
`endif
   output logic                         done
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RD_NUM0  = 3'd1;
   localparam logic [2:0] S_RD_NUM1  = 3'd2;
   localparam logic [2:0] S_WAIT_CNT = 3'd3;
   localparam logic [2:0] S_BCAST    = 3'd4;
   localparam logic [2:0] S_FINISH   = 3'd5;

   localparam logic [PARTICLE_ID_WIDTH-1:0] ID_ZERO = '0;
   localparam logic [PARTICLE_ID_WIDTH-1:0] ID_ONE  = {{(PARTICLE_ID_WIDTH-1){1'b0}}, 1'b1};

   logic [2:0]                   state;
   logic [PARTICLE_ID_WIDTH-1:0] cell_count;
   logic                         last_particle;
   logic                         last_ref;

   // Stall only matters while broadcasting; the count read is never held off.
   assign pause_reading = (state == S_BCAST) && (|filter_almost_full);

   // Full-width compares against the latched count, so the maximum count
   // (all ones) terminates without the counters ever wrapping.
   assign last_particle = (particle_id == cell_count);
   assign last_ref      = (ref_id == cell_count);

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= S_IDLE;
         cell_count           <= ID_ZERO;
         phase                <= 1'b0;
         reading_particle_num <= 1'b0;
         ref_id               <= ID_ZERO;
         particle_id          <= ID_ZERO;
         busy                 <= 1'b0;
         done                 <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state                <= S_RD_NUM0;
                  busy                 <= 1'b1;
                  reading_particle_num <= 1'b1;
                  phase                <= 1'b0;
                  ref_id               <= ID_ZERO;
                  particle_id          <= ID_ZERO;
               end
            end

            S_RD_NUM0: begin
               state <= S_RD_NUM1;
               phase <= 1'b1;
            end

            S_RD_NUM1: begin
               state                <= S_WAIT_CNT;
               phase                <= 1'b0;
               reading_particle_num <= 1'b0;
            end

            S_WAIT_CNT: begin
               // Count is held here for the whole pass; later input changes
               // are deliberately ignored.
               cell_count <= home_particle_count;
               if (home_particle_count == ID_ZERO) begin
                  state <= S_FINISH;
                  done  <= 1'b1;
               end else begin
                  state       <= S_BCAST;
                  ref_id      <= ID_ONE;
                  particle_id <= ID_ONE;
                  phase       <= 1'b0;
               end
            end

            S_BCAST: begin
               if (!pause_reading) begin
                  if (!phase) begin
                     phase <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     if (last_particle) begin
                        if (last_ref) begin
                           state       <= S_FINISH;
                           done        <= 1'b1;
                           ref_id      <= ID_ZERO;
                           particle_id <= ID_ZERO;
                        end else begin
                           particle_id <= ID_ONE;
                           ref_id      <= ref_id + ID_ONE;
                        end
                     end else begin
                        particle_id <= particle_id + ID_ONE;
                     end
                  end
               end
            end

            S_FINISH: begin
               // start arriving here is dropped: only IDLE accepts it.
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state                <= S_IDLE;
               busy                 <= 1'b0;
               phase                <= 1'b0;
               reading_particle_num <= 1'b0;
               ref_id               <= ID_ZERO;
               particle_id          <= ID_ZERO;
            end
         endcase
      end
   end

`ifdef MD_SEQ_STALL_CNT_EN
   // Cleared by an accepted start; keeps its value after done so the
   // controller can read it between passes.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if ((state == S_IDLE) && start) begin
         stall_cycles <= '0;
      end else if (pause_reading && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_md_read_sequencer.sv
module tb_md_read_sequencer;

   localparam int W  = 7;
   localparam int NF = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [NF-1:0] faf;
   logic [W-1:0]  hpc;
   logic          phase;
   logic          rpn;
   logic          pause;
   logic [W-1:0]  ref_id;
   logic [W-1:0]  pid;
   logic          busy;
   logic          done;
`ifdef MD_SEQ_STALL_CNT_EN
   logic [31:0]   stall_cycles;
`endif

   md_read_sequencer #(.PARTICLE_ID_WIDTH(W), .NUM_FILTER(NF)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .start                (start),
      .filter_almost_full   (faf),
      .home_particle_count  (hpc),
      .phase                (phase),
      .reading_particle_num (rpn),
      .pause_reading        (pause),
      .ref_id               (ref_id),
      .particle_id          (pid),
      .busy                 (busy),
`ifdef MD_SEQ_STALL_CNT_EN
      .stall_cycles         (stall_cycles),
`endif
      .done                 (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int n;          // home particle count
      int stall_at;   // BCAST step index where back-pressure starts (-1: none)
      int stall_len;  // stalled cycles
      int start_at;   // BCAST step index at which a stray start is driven (-1: none)
      bit start_fin;  // drive a stray start in the FINISH cycle
      int exp_done;   // expected done cycle, start sampled at edge 0
   } vec_t;

   vec_t vecs[7];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(negedge clk);
      cyc++;
      start = 1'b0;
      faf   = '0;
   endtask

   task automatic run_pass(input vec_t v);
      int k;
      int dcyc;
      int extra;
      int reps;
      @(negedge clk);
      cyc   = 0;
      start = 1'b1;
      faf   = '0;
      hpc   = 7'd5;
      // count-read cycles: back-pressure must not stall them
      for (int c = 1; c <= 3; c++) begin
         next_cyc();
         faf = '1;
         hpc = (c == 3) ? 7'(v.n) : 7'd5;
         #1;
         chk("pause_rd", pause, 0);
         chk("ref_rd", ref_id, 0);
         chk("busy_rd", busy, 1);
         chk("done_rd", done, 0);
         chk("rpn_rd", rpn, (c < 3) ? 1 : 0);
         if (c < 3) begin
            chk("pid_rd", pid, 0);
            chk("phase_rd", phase, (c == 2) ? 1 : 0);
         end
      end
      k = 0;
      for (int r = 1; r <= v.n; r++)
         for (int p = 1; p <= v.n; p++)
            for (int ph = 0; ph < 2; ph++) begin
               reps = (k == v.stall_at) ? v.stall_len + 1 : 1;
               for (int rep = 0; rep < reps; rep++) begin
                  next_cyc();
                  hpc = 7'(v.n) ^ 7'h55;
                  faf = (k == v.stall_at && rep < v.stall_len) ? 7'b0000100 : 7'b0;
                  if (k == v.start_at && rep == 0) start = 1'b1;
                  #1;
                  chk("phase", phase, ph);
                  chk("ref_id", ref_id, r);
                  chk("particle_id", pid, p);
                  chk("pause", pause, (faf != 0) ? 1 : 0);
                  chk("rpn_bc", rpn, 0);
                  chk("busy_bc", busy, 1);
                  chk("done_bc", done, 0);
               end
               k++;
            end
      dcyc = -1;
      for (int i = 0; i < 3 && dcyc < 0; i++) begin
         next_cyc();
         if (i == 0 && v.start_fin) start = 1'b1;
         #1;
         if (done) begin
            dcyc = cyc;
            chk("busy_fin", busy, 1);
         end
      end
      chk("done_cycle", dcyc, v.exp_done);
      next_cyc();
      #1;
      chk("busy_after", busy, 0);
      chk("done_after", done, 0);
      chk("ref_after", ref_id, 0);
      chk("pid_after", pid, 0);
      chk("phase_after", phase, 0);
`ifdef MD_SEQ_STALL_CNT_EN
      chk("stall_cycles", stall_cycles, v.stall_len);
`endif
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         next_cyc();
         #1;
         if (done || busy) extra++;
      end
      chk("no_extra_pass", extra, 0);
   endtask

   initial begin
      vecs[0] = '{n: 3,   stall_at: -1, stall_len: 0, start_at: -1, start_fin: 0, exp_done: 22};
      vecs[1] = '{n: 0,   stall_at: -1, stall_len: 0, start_at: -1, start_fin: 0, exp_done: 4};
      vecs[2] = '{n: 2,   stall_at: 3,  stall_len: 3, start_at: -1, start_fin: 0, exp_done: 15};
      vecs[3] = '{n: 1,   stall_at: 0,  stall_len: 2, start_at: 1,  start_fin: 1, exp_done: 8};
      vecs[4] = '{n: 3,   stall_at: -1, stall_len: 0, start_at: 5,  start_fin: 1, exp_done: 22};
      vecs[5] = '{n: 2,   stall_at: 7,  stall_len: 1, start_at: -1, start_fin: 0, exp_done: 13};
      vecs[6] = '{n: 127, stall_at: -1, stall_len: 0, start_at: -1, start_fin: 0, exp_done: 32262};

      cyc   = 0;
      rst   = 1'b1;
      start = 1'b0;
      faf   = '0;
      hpc   = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_phase", phase, 0);
      chk("rst_rpn", rpn, 0);
      chk("rst_pause", pause, 0);
      chk("rst_ref", ref_id, 0);
      chk("rst_pid", pid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) run_pass(vecs[i]);

      // abort an N=4 pass at (2,1)p0 with reset
      @(negedge clk);
      cyc   = 0;
      start = 1'b1;
      hpc   = 7'd4;
      for (int c = 1; c <= 3 + 9; c++) next_cyc();
      #1;
      chk("abort_ref", ref_id, 2);
      chk("abort_pid", pid, 1);
      chk("abort_phase", phase, 0);
      faf = 7'b1000000;
      rst = 1'b1;
      @(negedge clk);
      cyc++;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_ref0", ref_id, 0);
      chk("abort_pid0", pid, 0);
      chk("abort_phase0", phase, 0);
      chk("abort_rpn0", rpn, 0);
      chk("abort_pause0", pause, 0);
`ifdef MD_SEQ_STALL_CNT_EN
      chk("abort_stall_cnt", stall_cycles, 0);
`endif
      rst = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 6; i++) begin
            next_cyc();
            #1;
            if (done || busy) seen++;
         end
         chk("abort_no_done", seen, 0);
      end
      run_pass('{n: 4, stall_at: -1, stall_len: 0, start_at: -1, start_fin: 0, exp_done: 36});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
